halut_decoder: RTL and testbench
================================

# halut_decoder

Consumer side of the HALUT encoder interface. The block takes the `(c_addr, k_addr, valid)` prototype-index stream produced by the encoder units and reads a signed partial-product LUT entry for each index. It accumulates one entry per codebook over all C codebooks of a row and emits one result per row. One instance serves one output column; the LUT is loaded through a write port, mirroring the encoder's threshold-memory write port.

## Interface

Parameters:
- `K`, default 16: prototypes per codebook.
- `C`, default 32: codebooks per row.
- `DataTypeWidth`, default 16: LUT entry width, signed two's complement.
- `RowWidth`, default 16: width of the row counter.
- `TreeDepth`, default `$clog2(K)`: k address width.
- `CAddrWidth`, default `$clog2(C)`: c address width.
- `LutAddrWidth`, default `$clog2(C*K)`: LUT address width.
- `AccWidth`, default `DataTypeWidth + $clog2(C)`: accumulator and result width.

Ports:
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `decoder_i`  in  1  enable; low flushes and holds the block idle.
- `c_addr_i`  in  CAddrWidth  codebook index.
- `k_addr_i`  in  TreeDepth  prototype index.
- `valid_i`  in  1  index pair valid this cycle.
- `waddr_i`  in  LutAddrWidth  LUT write address, laid out as `{c, k}`.
- `wdata_i`  in  DataTypeWidth  LUT write data.
- `we_i`  in  1  LUT write enable.
- `result_o`  out  AccWidth  signed row sum.
- `row_o`  out  RowWidth  index of the row in `result_o`.
- `valid_o`  out  1  one-cycle pulse marking a new `result_o`.

## Operation

LUT:
- C*K × DataTypeWidth latch/flop memory (team `scm` style).
- Write is synchronous: `lut[waddr_i] <= wdata_i` when `we_i` is high.
- Read is combinational from the registered address `{c_q, k_q}`.
- A read and a write to the same address in the same cycle return the old data.
- LUT contents are not reset.

Pipeline:
- Stage 0 registers `c_addr_i`, `k_addr_i` and `valid_i & decoder_i` into `c_q`, `k_q`, `v_q`.
- Stage 1 reads the LUT. When `v_q` is high:
  - Sign-extend the entry to AccWidth.
  - If `cnt == 0`, load `acc` with the entry; otherwise `acc <= acc + entry`.
  - Increment `cnt`.

Row completion (when `v_q` is high and `cnt == C-1`):
- `result_o <= acc + entry`, or the entry alone when C == 1.
- `valid_o <= 1`.
- `cnt <= 0`.
- `row_o` increments in the cycle after the pulse; it wraps modulo 2^RowWidth.
- A stage-1 entry arriving in the cycle right after completion starts the next row with `cnt == 0`. No bubble is needed.

Order and gaps:
- Codebook order within a row is not checked; the block counts exactly C valid entries per row.
- Gaps (`valid_i` low) are allowed anywhere and do not advance `cnt`.

States:
- IDLE (`decoder_i` low): `v_q`, `cnt`, `acc`, `valid_o`, `row_o` and `result_o` are all cleared to 0 at the next edge.
- RUN (`decoder_i` high): behaviour as described above.
- IDLE→RUN occurs when `decoder_i` rises; the first index may be presented in that same cycle.
- RUN→IDLE occurs when `decoder_i` falls.
  - A partial row is discarded.
  - An entry already in stage 1 is dropped.
  - No `valid_o` is produced for an incomplete row.

Arithmetic: AccWidth is sized so that C entries of minimum or maximum value cannot overflow. No saturation logic is needed.

## Timing

- Reset values: `result_o = 0`, `row_o = 0`, `valid_o = 0`, `cnt = 0`, `acc = 0`, `v_q = 0`.
- Latency: the last index of a row presented in cycle t produces `valid_o` high and `result_o` valid in cycle t+2.
- Throughput: one index per cycle. With back-to-back rows, `valid_o` pulses every C cycles.
- `valid_o` is high for exactly one cycle per row. `result_o` holds its value until the next row completes or the block goes to IDLE.
- `row_o` equals the index of the row being presented while `valid_o` is high, and advances on the next edge.
- A LUT write in cycle t is visible to a stage-1 read in cycle t+1.
- Asserting `rst_ni` mid-row clears all state immediately. After release, the block behaves as if freshly enabled.

## Test plan

- **Basic row:** load `lut[{c,k}] = c`; with `decoder_i=1`, feed c=0..31 with k=5 on consecutive cycles → a single `valid_o` pulse 2 cycles after the last input, with `result_o = 496` and `row_o = 0`.
- **Back-to-back rows with gaps:** load `lut = k`; feed row A (all k=15), then immediately row B (all k=1), with random `valid_i` gaps inside B → pulses with 480 (row 0) and 32 (row 1); no extra pulses.
- **Extreme values:** load all entries with −32768 → `result_o = −1048576`; load all entries with 32767 → `result_o = 1048544`; no wrap in either case.
- **Disable mid-row:** feed 10 entries, drop `decoder_i` for one cycle, re-enable, then feed a full row of `lut = 1` → exactly one pulse with `result_o = 32`; `row_o = 0`.
- **Write/read collision:** write 7 to `lut[{3,2}]` in the same cycle that stage 1 reads `{3,2}` (old value 1) → the sum uses 1. In the following row the sum uses 7.
- **Async reset mid-row:** pulse `rst_ni` low between cycles → all outputs are 0 immediately. The next full row (`lut = 2`) gives `result_o = 64`, `row_o = 0`.

Source files
------------

// File: rtl/halut_decoder_if.sv
// Index stream, LUT write port and row-result signals between the HALUT encoder side and one decoder column.
// dbg_run mirrors the decoder's IDLE/RUN state.
interface halut_decoder_if #(
  parameter int unsigned K             = 16,
  parameter int unsigned C             = 32,
  parameter int unsigned DataTypeWidth = 16,
  parameter int unsigned RowWidth      = 16,
  parameter int unsigned TreeDepth     = $clog2(K),
  parameter int unsigned CAddrWidth    = $clog2(C),
  parameter int unsigned LutAddrWidth  = $clog2(C * K),
  parameter int unsigned AccWidth      = DataTypeWidth + $clog2(C)
);
  // No backpressure: valid qualifies c_addr/k_addr in the cycle it is high and
  // is always consumed; res_valid is a one-cycle pulse qualifying result/row.
  logic                     decoder;
  logic [CAddrWidth-1:0]    c_addr;
  logic [TreeDepth-1:0]     k_addr;
  logic                     valid;
  logic [LutAddrWidth-1:0]  waddr;
  logic [DataTypeWidth-1:0] wdata;
  logic                     we;
  logic [AccWidth-1:0]      result;
  logic [RowWidth-1:0]      row;
  logic                     res_valid;
  logic                     dbg_run;

  modport master (
    output decoder, c_addr, k_addr, valid, waddr, wdata, we,
    input  result, row, res_valid, dbg_run
  );

  modport slave (
    input  decoder, c_addr, k_addr, valid, waddr, wdata, we,
    output result, row, res_valid, dbg_run
  );
endinterface

// File: rtl/halut_decoder.sv
// HALUT decoder column: looks up one signed LUT entry per (c, k) index and
// sums C entries per row, emitting one result pulse per completed row.
module halut_decoder #(
  parameter int unsigned K             = 16,
  parameter int unsigned C             = 32,
  parameter int unsigned DataTypeWidth = 16,
  parameter int unsigned RowWidth      = 16,
  parameter int unsigned TreeDepth     = $clog2(K),
  parameter int unsigned CAddrWidth    = $clog2(C),
  parameter int unsigned LutAddrWidth  = $clog2(C * K),
  parameter int unsigned AccWidth      = DataTypeWidth + $clog2(C)
) (
  input logic           clk_i,
  input logic           rst_ni,
  halut_decoder_if.slave bus
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int unsigned CntWidth = (C > 1) ? $clog2(C) : 1;
  localparam int unsigned ExtWidth = AccWidth - DataTypeWidth;

  state_e                     state;
  logic [CAddrWidth-1:0]      c_q;
  logic [TreeDepth-1:0]       k_q;
  logic                       v_q;
  logic [CntWidth-1:0]        cnt;
  logic signed [AccWidth-1:0] acc;
  logic signed [AccWidth-1:0] result;
  logic [RowWidth-1:0]        row;
  logic                       res_valid;

  logic [DataTypeWidth-1:0]   lut [C * K];
  logic [DataTypeWidth-1:0]   entry;
  logic signed [AccWidth-1:0] entry_ext;
  logic signed [AccWidth-1:0] sum;
  logic                       last;

  // Plain flop array, no reset; a same-cycle read sees the pre-write value.
  always_ff @(posedge clk_i) begin
    if (bus.we) begin
      lut[bus.waddr] <= bus.wdata;
    end
  end

  assign entry     = lut[{c_q, k_q}];
  assign entry_ext = {{ExtWidth{entry[DataTypeWidth-1]}}, entry};
  // The first entry of a row replaces acc, so no bubble is needed between rows.
  assign sum       = (cnt == '0) ? entry_ext : acc + entry_ext;
  assign last      = (cnt == CntWidth'(C - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= IDLE;
      c_q       <= '0;
      k_q       <= '0;
      v_q       <= 1'b0;
      cnt       <= '0;
      acc       <= '0;
      result    <= '0;
      row       <= '0;
      res_valid <= 1'b0;
    end else begin
      c_q <= bus.c_addr;
      k_q <= bus.k_addr;
      v_q <= bus.valid & bus.decoder;
      if (!bus.decoder) begin
        // Disabling discards any partial row and the entry in stage 1.
        state     <= IDLE;
        cnt       <= '0;
        acc       <= '0;
        result    <= '0;
        row       <= '0;
        res_valid <= 1'b0;
      end else begin
        state     <= RUN;
        res_valid <= 1'b0;
        if (res_valid) begin
          row <= row + 1'b1;
        end
        if (v_q) begin
          acc <= sum;
          if (last) begin
            result    <= sum;
            res_valid <= 1'b1;
            cnt       <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      end
    end
  end

  assign bus.result    = result;
  assign bus.row       = row;
  assign bus.res_valid = res_valid;
  assign bus.dbg_run   = (state == RUN);

endmodule

// File: tb/tb_halut_decoder.sv
// Self-checking bench for halut_decoder: random rows against a LUT/row-sum model.
module tb_halut_decoder;
  localparam int K   = 16;
  localparam int C   = 32;
  localparam int DW  = 16;
  localparam int RW  = 16;
  localparam int TD  = 4;
  localparam int CAW = 5;
  localparam int LAW = 9;
  localparam int AW  = 21;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  halut_decoder_if bus ();
  halut_decoder dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int row_m    = 0;
  int lut_m[C * K];

  logic [AW-1:0] exp_q[$];
  logic [RW-1:0] exp_row_q[$];
  logic [AW-1:0] obs_q[$];
  logic [RW-1:0] obs_row_q[$];
  int            obs_cyc_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.res_valid === 1'b1) begin
      obs_q.push_back(bus.result);
      obs_row_q.push_back(bus.row);
      obs_cyc_q.push_back(cyc);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input int c, input int k);
    @(posedge clk); #1;
    bus.valid  = v;
    bus.c_addr = c[CAW-1:0];
    bus.k_addr = k[TD-1:0];
    bus.we     = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 0, 0);
  endtask

  task automatic lut_write(input int a, input int d);
    @(posedge clk); #1;
    bus.valid = 1'b0;
    bus.we    = 1'b1;
    bus.waddr = a[LAW-1:0];
    bus.wdata = d[DW-1:0];
    lut_m[a]  = d;
  endtask

  // mode 0: entry = c, 1: entry = k, 2: entry = val, 3: random signed
  task automatic load_lut(input int mode, input int val);
    int d;
    for (int a = 0; a < C * K; a++) begin
      case (mode)
        0:       d = a / K;
        1:       d = a % K;
        2:       d = val;
        default: d = int'($urandom_range(0, 65535)) - 32768;
      endcase
      lut_write(a, d);
    end
    idle_cycles(1);
  endtask

  task automatic clear_queues();
    exp_q.delete(); exp_row_q.delete();
    obs_q.delete(); obs_row_q.delete(); obs_cyc_q.delete();
  endtask

  task automatic restart();
    @(posedge clk); #1;
    bus.decoder = 1'b0; bus.valid = 1'b0; bus.we = 1'b0;
    @(posedge clk); #1;
    bus.decoder = 1'b1;
    row_m = 0;
    clear_queues();
  endtask

  // One full row of C indices; kfix < 0 picks random k per codebook.
  task automatic feed_row(input int kfix, input bit shuf, input int gap_pct, output int last_cyc);
    int ord[C];
    int s, c, k, j, t;
    s = 0;
    last_cyc = 0;
    for (int i = 0; i < C; i++) ord[i] = i;
    if (shuf) begin
      for (int i = C - 1; i > 0; i--) begin
        j = int'($urandom_range(0, i));
        t = ord[i]; ord[i] = ord[j]; ord[j] = t;
      end
    end
    for (int i = 0; i < C; i++) begin
      c = ord[i];
      k = (kfix < 0) ? int'($urandom_range(0, K - 1)) : kfix;
      if (int'($urandom_range(0, 99)) < gap_pct) drive(1'b0, 0, 0);
      drive(1'b1, c, k);
      s += lut_m[c * K + k];
      last_cyc = cyc;
    end
    exp_q.push_back(AW'(s));
    exp_row_q.push_back(RW'(row_m));
    row_m++;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    bus.decoder = 1'b0; bus.valid = 1'b0; bus.we = 1'b0;
    bus.c_addr = '0; bus.k_addr = '0; bus.waddr = '0; bus.wdata = '0;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.result !== '0) begin failures++; $display("FAIL reset_result got=%0d exp=0", bus.result); end
    checks++; if (bus.row !== '0) begin failures++; $display("FAIL reset_row got=%0d exp=0", bus.row); end
    checks++; if (bus.res_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.res_valid); end
    checks++; if (bus.dbg_run !== 1'b0) begin failures++; $display("FAIL reset_state got=%b exp=0", bus.dbg_run); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic_row();
    int lc;
    load_lut(0, 0);
    restart();
    feed_row(5, 1'b0, 0, lc);
    idle_cycles(5);
    @(negedge clk);
    checks++;
    if (obs_q.size() != 1) begin
      failures++; $display("FAIL basic_pulses got=%0d exp=1", obs_q.size());
    end else begin
      checks++; if (obs_q[0] !== AW'(496)) begin failures++; $display("FAIL basic_result got=%0d exp=496", $signed(obs_q[0])); end
      checks++; if (obs_row_q[0] !== '0) begin failures++; $display("FAIL basic_row got=%0d exp=0", obs_row_q[0]); end
      checks++; if (obs_cyc_q[0] != lc + 2) begin failures++; $display("FAIL basic_latency got=%0d exp=%0d", obs_cyc_q[0], lc + 2); end
    end
    checks++; if (bus.result !== AW'(496)) begin failures++; $display("FAIL basic_hold got=%0d exp=496", $signed(bus.result)); end
    checks++; if (bus.row !== RW'(1)) begin failures++; $display("FAIL basic_row_adv got=%0d exp=1", bus.row); end
    checks++; if (bus.dbg_run !== 1'b1) begin failures++; $display("FAIL basic_state got=%b exp=1", bus.dbg_run); end
  endtask

  task automatic test_back_to_back();
    int la, lb, lc;
    load_lut(1, 0);
    restart();
    feed_row(15, 1'b1, 0, la);
    feed_row(1, 1'b1, 30, lb);
    feed_row(15, 1'b0, 0, lc);
    idle_cycles(5);
    checks++;
    if (obs_q.size() != 3) begin
      failures++; $display("FAIL b2b_pulses got=%0d exp=3", obs_q.size());
    end else begin
      checks++; if (obs_q[0] !== AW'(480)) begin failures++; $display("FAIL b2b_row_a got=%0d exp=480", $signed(obs_q[0])); end
      checks++; if (obs_q[1] !== AW'(32)) begin failures++; $display("FAIL b2b_row_b got=%0d exp=32", $signed(obs_q[1])); end
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i] || obs_row_q[i] !== exp_row_q[i]) begin
          failures++;
          $display("FAIL b2b_model[%0d] got=%0d/row%0d exp=%0d/row%0d", i, $signed(obs_q[i]), obs_row_q[i], $signed(exp_q[i]), exp_row_q[i]);
        end
      end
      checks++; if (obs_cyc_q[2] - obs_cyc_q[1] != C) begin failures++; $display("FAIL b2b_throughput got=%0d exp=%0d", obs_cyc_q[2] - obs_cyc_q[1], C); end
    end
  endtask

  task automatic test_extreme();
    int lc;
    load_lut(2, -32768);
    restart();
    feed_row(-1, 1'b1, 10, lc);
    idle_cycles(4);
    checks++;
    if (obs_q.size() != 1 || obs_q[0] !== AW'(-1048576)) begin
      failures++; $display("FAIL extreme_min got=%0d exp=-1048576 pulses=%0d", $signed(bus.result), obs_q.size());
    end
    load_lut(2, 32767);
    restart();
    feed_row(-1, 1'b1, 10, lc);
    idle_cycles(4);
    checks++;
    if (obs_q.size() != 1 || obs_q[0] !== AW'(1048544)) begin
      failures++; $display("FAIL extreme_max got=%0d exp=1048544 pulses=%0d", $signed(bus.result), obs_q.size());
    end
  endtask

  task automatic test_disable_mid_row();
    int lc;
    load_lut(2, 1);
    clear_queues();
    for (int i = 0; i < 10; i++) drive(1'b1, i, 3);
    @(posedge clk); #1;
    bus.decoder = 1'b0; bus.valid = 1'b1; bus.c_addr = 5'd10;
    @(posedge clk); #1;
    bus.decoder = 1'b1; bus.valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.result !== '0 || bus.row !== '0 || bus.res_valid !== 1'b0 || bus.dbg_run !== 1'b0) begin
      failures++; $display("FAIL disable_clear got=%0d/row%0d/v%b exp=0/row0/v0", $signed(bus.result), bus.row, bus.res_valid);
    end
    row_m = 0;
    feed_row(-1, 1'b1, 0, lc);
    idle_cycles(4);
    checks++;
    if (obs_q.size() != 1 || obs_q[0] !== AW'(32) || obs_row_q[0] !== '0) begin
      failures++; $display("FAIL disable_row got=%0d/row%0d pulses=%0d exp=32/row0 pulses=1", $signed(bus.result), bus.row, obs_q.size());
    end
  endtask

  task automatic test_collision();
    restart();
    for (int c = 0; c < C; c++) begin
      @(posedge clk); #1;
      bus.valid = 1'b1; bus.c_addr = c[CAW-1:0];
      bus.k_addr = (c == 3) ? 4'd2 : 4'd0;
      bus.we = (c == 4); bus.waddr = 9'(3 * K + 2); bus.wdata = 16'd7;
    end
    lut_m[3 * K + 2] = 7;
    for (int c = 0; c < C; c++) drive(1'b1, c, (c == 3) ? 2 : 0);
    idle_cycles(4);
    checks++;
    if (obs_q.size() != 2) begin
      failures++; $display("FAIL collision_pulses got=%0d exp=2", obs_q.size());
    end else begin
      checks++; if (obs_q[0] !== AW'(32)) begin failures++; $display("FAIL collision_old got=%0d exp=32", $signed(obs_q[0])); end
      checks++; if (obs_q[1] !== AW'(38) || obs_row_q[1] !== RW'(1)) begin failures++; $display("FAIL collision_new got=%0d/row%0d exp=38/row1", $signed(obs_q[1]), obs_row_q[1]); end
    end
  endtask

  task automatic test_async_reset();
    int lc;
    load_lut(2, 2);
    for (int i = 0; i < 10; i++) drive(1'b1, i, 1);
    @(negedge clk); #2;
    bus.valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.result !== '0 || bus.row !== '0 || bus.res_valid !== 1'b0) begin
      failures++; $display("FAIL async_reset got=%0d/row%0d/v%b exp=0/row0/v0", $signed(bus.result), bus.row, bus.res_valid);
    end
    @(negedge clk); #2;
    rst_n = 1'b1;
    clear_queues();
    row_m = 0;
    feed_row(-1, 1'b1, 20, lc);
    idle_cycles(4);
    checks++;
    if (obs_q.size() != 1 || obs_q[0] !== AW'(64) || obs_row_q[0] !== '0) begin
      failures++; $display("FAIL async_next_row got=%0d/row%0d pulses=%0d exp=64/row0 pulses=1", $signed(bus.result), bus.row, obs_q.size());
    end
  endtask

  task automatic test_random();
    int lc;
    load_lut(3, 0);
    restart();
    for (int r = 0; r < 8; r++) feed_row(-1, 1'b1, (r % 2 == 0) ? 0 : 35, lc);
    idle_cycles(5);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++; $display("FAIL random_pulses got=%0d exp=%0d", obs_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i] || obs_row_q[i] !== exp_row_q[i]) begin
          failures++;
          $display("FAIL random_row[%0d] got=%0d/row%0d exp=%0d/row%0d", i, $signed(obs_q[i]), obs_row_q[i], $signed(exp_q[i]), exp_row_q[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_row();
    test_back_to_back();
    test_extreme();
    test_disable_mid_row();
    test_collision();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
